bp_update_ctrl: RTL and testbench

Sits between the EX-stage branch resolution logic and the branch predictor's update port. It buffers resolved control-flow instructions in a small in-order queue and drains them into the predictor at one per cycle. It also compares each prediction against the actual outcome, issues the fetch redirect/flush on a misprediction, and keeps branch/mispredict statistics.

---
 rtl/bp_update_ctrl_pkg.sv | 30 +++
 rtl/bp_update_ctrl_if.sv | 41 ++++
 rtl/bp_update_fifo.sv | 59 +++++
 rtl/bp_update_ctrl.sv | 150 +++++++++++++++
 tb/tb_bp_update_ctrl.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bp_update_ctrl_pkg.sv
// Shared types and constants for the branch predictor update controller.
// Opcode classes, the queued update record and the controller state.
package bp_update_ctrl_pkg;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [63:0] target;
  } bp_update_t;

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } bpu_state_e;

  function automatic logic is_ctrl_flow(input logic [31:0] instr);
    return (instr[6:0] == OP_BRANCH) || (instr[6:0] == OP_JAL) ||
           (instr[6:0] == OP_JALR);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/bp_update_ctrl_if.sv
// Resolve/update/redirect/statistics bundle between EX, the controller and the predictor.
// master drives resolves and the hold; slave is the controller.
interface bp_update_ctrl_if #(
  parameter int QDEPTH = 4
);
  logic                      resolve_valid;
  logic                      resolve_ready;
  logic [63:0]               resolve_pc;
  logic [31:0]               resolve_instr;
  logic                      resolve_taken;
  logic [63:0]               resolve_target;
  logic                      resolve_pred_taken;
  logic [63:0]               resolve_pred_target;
  logic                      upd_hold;
  logic                      update_en;
  logic [63:0]               update_pc;
  logic [31:0]               update_instr;
  logic                      actual_taken;
  logic [63:0]               actual_target;
  logic                      redirect_valid;
  logic [63:0]               redirect_pc;
  logic [31:0]               stat_branches;
  logic [31:0]               stat_mispredicts;
  logic [$clog2(QDEPTH):0]   q_count;

  modport master (
    output resolve_valid, resolve_pc, resolve_instr, resolve_taken, resolve_target,
           resolve_pred_taken, resolve_pred_target, upd_hold,
    input  resolve_ready, update_en, update_pc, update_instr, actual_taken,
           actual_target, redirect_valid, redirect_pc, stat_branches,
           stat_mispredicts, q_count
  );

  modport slave (
    input  resolve_valid, resolve_pc, resolve_instr, resolve_taken, resolve_target,
           resolve_pred_taken, resolve_pred_target, upd_hold,
    output resolve_ready, update_en, update_pc, update_instr, actual_taken,
           actual_target, redirect_valid, redirect_pc, stat_branches,
           stat_mispredicts, q_count
  );
endinterface

// File: rtl/bp_update_fifo.sv
// In-order queue of resolved control-flow updates awaiting the predictor.
// Head is read combinationally; occupancy is registered so full/empty carry no bypass.
module bp_update_fifo
  import bp_update_ctrl_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  bp_update_t              push_data,
  input  logic                    pop,
  output bp_update_t              head,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(QDEPTH):0] count
);

  localparam int AW = $clog2(QDEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW:0]   DEPTH_C = (AW + 1)'(QDEPTH);

  bp_update_t    mem [QDEPTH];
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem[rptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q] <= push_data;
  end

  // Pointers wrap naturally because QDEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bp_update_ctrl.sv
// Buffers resolved branches/jumps for the predictor update port, raises fetch
// redirects on mispredicts, and keeps saturating branch/mispredict statistics.
//
//   state   | meaning
//   RUN     | queue control-flow resolves, detect mispredicts
//   RECOVER | wrong-path window: accept and discard resolves for FLUSH_CYCLES cycles
module bp_update_ctrl
  import bp_update_ctrl_pkg::*;
#(
  parameter int QDEPTH       = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input logic              clk,
  input logic              reset_n,
  bp_update_ctrl_if.slave  bus
);

  localparam int FW = $clog2(FLUSH_CYCLES + 1);
  localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES);
  localparam logic [FW-1:0] FLUSH_ONE  = FW'(1);

  bpu_state_e              state_q, state_d;
  logic [FW-1:0]           flush_cnt_q, flush_cnt_d;
  logic                    redirect_q, redirect_d;
  logic [63:0]             redirect_pc_q, redirect_pc_d;
  logic [31:0]             stat_branches_q;
  logic [31:0]             stat_mispredicts_q;
  logic                    upd_en_q;
  bp_update_t              upd_data_q;

  logic                    ready_int;
  logic                    accept;
  logic                    mispredict;
  logic                    push;
  logic                    pop;
  logic                    br_inc;
  logic                    mp_inc;
  bp_update_t              push_data;
  bp_update_t              head;
  logic                    full;
  logic                    empty;
  logic [$clog2(QDEPTH):0] count;

  bp_update_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  // Ready depends only on registered state; held low while reset is asserted.
  assign ready_int = (state_q == RECOVER) || !full;
  assign accept    = bus.resolve_valid && ready_int;
  assign pop       = !empty && !bus.upd_hold;

  // A not-taken prediction that is correct ignores the (meaningless) target.
  assign mispredict = (bus.resolve_taken != bus.resolve_pred_taken) ||
                      (bus.resolve_taken && (bus.resolve_target != bus.resolve_pred_target));

  always_comb begin
    push_data.pc     = bus.resolve_pc;
    push_data.instr  = bus.resolve_instr;
    push_data.taken  = bus.resolve_taken;
    push_data.target = bus.resolve_target;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= RUN;
      flush_cnt_q   <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    flush_cnt_d   = flush_cnt_q;
    redirect_d    = 1'b0;
    redirect_pc_d = redirect_pc_q;
    push          = 1'b0;
    br_inc        = 1'b0;
    mp_inc        = 1'b0;
    case (state_q)
      RUN: begin
        if (accept && is_ctrl_flow(bus.resolve_instr)) begin
          push   = 1'b1;
          br_inc = 1'b1;
          if (mispredict) begin
            mp_inc        = 1'b1;
            redirect_d    = 1'b1;
            redirect_pc_d = bus.resolve_taken ? bus.resolve_target
                                              : bus.resolve_pc + 64'd4;
            state_d       = RECOVER;
            flush_cnt_d   = FLUSH_LOAD;
          end
        end
      end
      RECOVER: begin
        flush_cnt_d = flush_cnt_q - FLUSH_ONE;
        if (flush_cnt_q <= FLUSH_ONE) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (br_inc) stat_branches_q    <= sat_inc(stat_branches_q);
      if (mp_inc) stat_mispredicts_q <= sat_inc(stat_mispredicts_q);
    end
  end

  // Update fields keep their last values when nothing drains.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd_en_q   <= 1'b0;
      upd_data_q <= '0;
    end else begin
      upd_en_q <= pop;
      if (pop) upd_data_q <= head;
    end
  end

  assign bus.resolve_ready    = reset_n && ready_int;
  assign bus.update_en        = upd_en_q;
  assign bus.update_pc        = upd_data_q.pc;
  assign bus.update_instr     = upd_data_q.instr;
  assign bus.actual_taken     = upd_data_q.taken;
  assign bus.actual_target    = upd_data_q.target;
  assign bus.redirect_valid   = redirect_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.stat_branches    = stat_branches_q;
  assign bus.stat_mispredicts = stat_mispredicts_q;
  assign bus.q_count          = count;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Bench for bp_update_ctrl: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a queue-based reference model.
module tb_bp_update_ctrl;

  localparam int QD = 4;
  localparam int FL = 2;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic        taken;
    logic [63:0] target;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  bp_update_ctrl_if #(.QDEPTH(QD)) bus ();

  bp_update_ctrl #(.QDEPTH(QD), .FLUSH_CYCLES(FL)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  ent_t        m_q[$];
  int          m_flush = 0;
  logic        m_upd_en = 1'b0;
  ent_t        m_upd = '{pc: 64'h0, instr: 32'h0, taken: 1'b0, target: 64'h0};
  logic        m_redirect = 1'b0;
  logic [63:0] m_redirect_pc = 64'h0;
  logic [31:0] m_br = 32'h0;
  logic [31:0] m_mp = 32'h0;

  function automatic logic m_is_cf(input logic [31:0] ins);
    logic [6:0] op;
    op = ins[6:0];
    return op == 7'h63 || op == 7'h6F || op == 7'h67;
  endfunction

  function automatic logic m_ready();
    if (!reset_n) return 1'b0;
    return (m_flush > 0) || (m_q.size() < QD);
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_flush       = 0;
    m_upd_en      = 1'b0;
    m_upd         = '{pc: 64'h0, instr: 32'h0, taken: 1'b0, target: 64'h0};
    m_redirect    = 1'b0;
    m_redirect_pc = 64'h0;
    m_br          = 32'h0;
    m_mp          = 32'h0;
  endtask

  task automatic model_step();
    logic rdy;
    logic mp;
    ent_t e;
    if (!reset_n) return;
    rdy = m_ready();
    if (m_q.size() > 0 && !bus.upd_hold) begin
      m_upd    = m_q.pop_front();
      m_upd_en = 1'b1;
    end else begin
      m_upd_en = 1'b0;
    end
    m_redirect = 1'b0;
    if (m_flush > 0) begin
      m_flush = m_flush - 1;
    end else if (bus.resolve_valid && rdy && m_is_cf(bus.resolve_instr)) begin
      e.pc = bus.resolve_pc; e.instr = bus.resolve_instr;
      e.taken = bus.resolve_taken; e.target = bus.resolve_target;
      m_q.push_back(e);
      if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
      mp = (bus.resolve_taken != bus.resolve_pred_taken) ||
           (bus.resolve_taken && bus.resolve_target != bus.resolve_pred_target);
      if (mp) begin
        m_redirect    = 1'b1;
        m_redirect_pc = bus.resolve_taken ? bus.resolve_target : bus.resolve_pc + 64'd4;
        if (m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
        m_flush = FL;
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    chk("ready",          64'(bus.resolve_ready),    64'(m_ready()));
    chk("update_en",      64'(bus.update_en),        64'(m_upd_en));
    chk("update_pc",      bus.update_pc,             m_upd.pc);
    chk("update_instr",   64'(bus.update_instr),     64'(m_upd.instr));
    chk("actual_taken",   64'(bus.actual_taken),     64'(m_upd.taken));
    chk("actual_target",  bus.actual_target,         m_upd.target);
    chk("redirect_valid", 64'(bus.redirect_valid),   64'(m_redirect));
    chk("redirect_pc",    bus.redirect_pc,           m_redirect_pc);
    chk("stat_branches",  64'(bus.stat_branches),    64'(m_br));
    chk("stat_mispred",   64'(bus.stat_mispredicts), 64'(m_mp));
    chk("q_count",        64'(bus.q_count),          64'(m_q.size()));
  end

  task automatic drive(input logic v, input logic [63:0] pc, input logic [31:0] ins,
                       input logic tk, input logic [63:0] tg, input logic ptk,
                       input logic [63:0] ptg);
    bus.resolve_valid       = v;
    bus.resolve_pc          = pc;
    bus.resolve_instr       = ins;
    bus.resolve_taken       = tk;
    bus.resolve_target      = tg;
    bus.resolve_pred_taken  = ptk;
    bus.resolve_pred_target = ptg;
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.resolve_valid = 1'b0;
    for (int k = 0; k < n; k++) step();
  endtask

  localparam logic [31:0] I_BEQ  = 32'h0000_0063;
  localparam logic [31:0] I_BNE  = 32'h0000_1063;
  localparam logic [31:0] I_JAL  = 32'h0000_006F;
  localparam logic [31:0] I_JALR = 32'h0000_0067;
  localparam logic [31:0] I_ADDI = 32'h0010_0013;

  initial begin
    logic [31:0] ins;
    logic [63:0] pc, tg, ptg;
    logic        tk, ptk;
    int          sel;

    drive(1'b0, 64'h0, 32'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    bus.upd_hold = 1'b0;
    model_reset();
    #1;
    chk("rst_update_en", 64'(bus.update_en), 64'h0);
    chk("rst_ready", 64'(bus.resolve_ready), 64'h0);
    repeat (2) @(negedge clk);
    #1 reset_n = 1'b1;
    idle(2);

    // Correctly predicted BEQ
    drive(1'b1, 64'h1000, I_BEQ, 1'b1, 64'h1040, 1'b1, 64'h1040);
    step();
    chk("t1_qcount", 64'(bus.q_count), 64'd1);
    chk("t1_no_redirect", 64'(bus.redirect_valid), 64'd0);
    chk("t1_br", 64'(bus.stat_branches), 64'd1);
    idle(1);
    chk("t1_upd_en", 64'(bus.update_en), 64'd1);
    chk("t1_upd_pc", bus.update_pc, 64'h1000);
    chk("t1_mp", 64'(bus.stat_mispredicts), 64'd0);

    // Direction mispredict, then two wrong-path resolves
    drive(1'b1, 64'h2000, I_BNE, 1'b0, 64'h2100, 1'b1, 64'h2100);
    step();
    chk("t2_redirect", 64'(bus.redirect_valid), 64'd1);
    chk("t2_redirect_pc", bus.redirect_pc, 64'h2004);
    chk("t2_mp", 64'(bus.stat_mispredicts), 64'd1);
    drive(1'b1, 64'h2100, I_BEQ, 1'b1, 64'h2200, 1'b1, 64'h2200);
    step();
    chk("t2_redirect_1cyc", 64'(bus.redirect_valid), 64'd0);
    step();
    chk("t2_drop_q", 64'(bus.q_count), 64'd0);
    chk("t2_drop_br", 64'(bus.stat_branches), 64'd2);
    step();
    chk("t2_run_br", 64'(bus.stat_branches), 64'd3);
    chk("t2_run_q", 64'(bus.q_count), 64'd1);
    idle(2);

    // Target mispredict on JALR
    drive(1'b1, 64'h3000, I_JALR, 1'b1, 64'h5000, 1'b1, 64'h4000);
    step();
    chk("t3_redirect_pc", bus.redirect_pc, 64'h5000);
    idle(1);
    chk("t3_upd_pc", bus.update_pc, 64'h3000);
    chk("t3_act_tgt", bus.actual_target, 64'h5000);
    idle(2);

    // Not-taken mispredict at the top of the address space wraps to 0
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, I_BNE, 1'b0, 64'h10, 1'b1, 64'h10);
    step();
    chk("t4_wrap_pc", bus.redirect_pc, 64'h0);
    idle(3);

    // Backpressure with hold
    bus.upd_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h100 + 64'(4 * i), I_BEQ, 1'b0, 64'h0, 1'b0, 64'h0);
      step();
    end
    chk("t5_full_q", 64'(bus.q_count), 64'd4);
    chk("t5_not_ready", 64'(bus.resolve_ready), 64'd0);
    drive(1'b1, 64'h110, I_BEQ, 1'b0, 64'h0, 1'b0, 64'h0);
    step();
    chk("t5_blocked_br", 64'(bus.stat_branches), 64'd9);
    bus.upd_hold = 1'b0;
    bus.resolve_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t5_drain_en", 64'(bus.update_en), 64'd1);
      chk("t5_drain_pc", bus.update_pc, 64'h100 + 64'(4 * i));
      if (i == 0) chk("t5_ready_back", 64'(bus.resolve_ready), 64'd1);
    end
    idle(1);

    // Non-control-flow is accepted but dropped, even with bogus prediction
    drive(1'b1, 64'h600, I_ADDI, 1'b1, 64'h700, 1'b0, 64'h0);
    step();
    chk("t6_addi_q", 64'(bus.q_count), 64'd0);
    chk("t6_addi_br", 64'(bus.stat_branches), 64'd9);
    chk("t6_addi_redir", 64'(bus.redirect_valid), 64'd0);

    // Reset mid-drain
    bus.upd_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 64'h200 + 64'(4 * i), I_JAL, 1'b1, 64'h800, 1'b1, 64'h800);
      step();
    end
    bus.upd_hold = 1'b0;
    idle(1);
    chk("t7_q3", 64'(bus.q_count), 64'd3);
    #1 reset_n = 1'b0;
    model_reset();
    #1;
    chk("t7_rst_en", 64'(bus.update_en), 64'd0);
    chk("t7_rst_pc", bus.update_pc, 64'd0);
    chk("t7_rst_q", 64'(bus.q_count), 64'd0);
    chk("t7_rst_br", 64'(bus.stat_branches), 64'd0);
    chk("t7_rst_ready", 64'(bus.resolve_ready), 64'd0);
    @(negedge clk);
    #1 reset_n = 1'b1;
    idle(2);
    chk("t7_after_q", 64'(bus.q_count), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = $urandom_range(0, 7);
      ins = $urandom;
      case (sel)
        0, 1, 2: ins[6:0] = 7'b1100011;
        3:       ins[6:0] = 7'b1101111;
        4:       ins[6:0] = 7'b1100111;
        default: ins[6:0] = 7'($urandom_range(0, 127));
      endcase
      pc  = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
      tg  = {$urandom, $urandom};
      tk  = 1'($urandom_range(0, 1));
      ptk = ($urandom_range(0, 3) == 0) ? ~tk : tk;
      ptg = ($urandom_range(0, 3) == 0) ? {$urandom, $urandom} : tg;
      drive(($urandom_range(0, 9) < 7), pc, ins, tk, tg, ptk, ptg);
      bus.upd_hold = ($urandom_range(0, 3) == 0);
      step();
    end
    bus.upd_hold = 1'b0;
    idle(8);

    // Saturation of the branch counter
    force dut.stat_branches_q = 32'hFFFF_FFFF;
    #1 release dut.stat_branches_q;
    m_br = 32'hFFFF_FFFF;
    drive(1'b1, 64'h9000, I_BEQ, 1'b0, 64'h0, 1'b0, 64'h0);
    step();
    chk("t9_sat", 64'(bus.stat_branches), 64'hFFFF_FFFF);
    drive(1'b1, 64'h9004, I_BEQ, 1'b0, 64'h0, 1'b0, 64'h0);
    step();
    chk("t9_sat2", 64'(bus.stat_branches), 64'hFFFF_FFFF);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
